// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: core data-memory controller driving a word-wide synchronous SRAM.
// Sub-word stores use read-modify-write; optional alignment trap via DMEM_MISALIGN_TRAP_EN.
module data_mem_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       addr,
    input  logic [31:0]       wr_data,
    input  logic              memwrite,
    input  logic              memread,
    input  logic [3:0]        sign_mask,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              fault,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    output logic              sram_we,
    output logic              sram_re,
    input  logic [31:0]       sram_rdata
);
    typedef enum logic [1:0] {IDLE, LOAD, MERGE} state_t;
    state_t state, state_nx;
    logic [ADDR_W-1:0] waddr_q;
    logic [1:0]        lane_q;
    logic [2:0]        size_q;
    logic              sgn_q;
    logic [15:0]       wdata_q;
    logic              req, mis;
    logic [3:0]        be;
    logic [31:0]       rep, merged, load_fmt;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic              unused_addr;
    assign unused_addr = ^addr[31:ADDR_W+2];
    assign req = memread | memwrite;
`ifdef DMEM_MISALIGN_TRAP_EN
    assign mis = (sign_mask[2:0] == 3'b011 && addr[0]) || (sign_mask[2:0] == 3'b111 && addr[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif
    assign busy = rst_n && state != IDLE;
    // Lane byte-enables and replicated store data for the read-modify-write merge
    assign be  = size_q == 3'b011 ? (lane_q[1] ? 4'b1100 : 4'b0011) : 4'b0001 << lane_q;
    assign rep = size_q == 3'b011 ? {2{wdata_q}} : {4{wdata_q[7:0]}};
    for (genvar b = 0; b < 4; b++) begin : g_merge
        assign merged[8*b +: 8] = be[b] ? rep[8*b +: 8] : sram_rdata[8*b +: 8];
    end
    assign byte_v   = sram_rdata[{lane_q, 3'b000} +: 8];
    assign half_v   = lane_q[1] ? sram_rdata[31:16] : sram_rdata[15:0];
    assign load_fmt = size_q == 3'b111 ? sram_rdata :
                      size_q == 3'b011 ? {{16{sgn_q & half_v[15]}}, half_v} :
                                         {{24{sgn_q & byte_v[7]}}, byte_v};
    always_comb begin
        state_nx   = state;
        sram_we    = 1'b0;
        sram_re    = 1'b0;
        sram_addr  = addr[ADDR_W+1:2];
        sram_wdata = wr_data;
        case (state)
            IDLE: if (req && !mis) begin
                if (memwrite && sign_mask[2:0] == 3'b111) begin
                    sram_we = 1'b1;
                end else begin
                    sram_re  = 1'b1;
                    state_nx = memwrite ? MERGE : LOAD;
                end
            end
            MERGE: begin
                sram_we    = 1'b1;
                sram_addr  = waddr_q;
                sram_wdata = merged;
                state_nx   = IDLE;
            end
            default: begin
                sram_addr = waddr_q;
                state_nx  = IDLE;
            end
        endcase
        if (!rst_n) begin
            sram_we  = 1'b0;
            sram_re  = 1'b0;
            state_nx = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            rd_data  <= 32'h0;
            rd_valid <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state    <= state_nx;
            rd_valid <= state == LOAD;
            fault    <= state == IDLE && req && mis;
            if (state == LOAD) rd_data <= load_fmt;
        end
    end
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            waddr_q <= addr[ADDR_W+1:2];
            lane_q  <= addr[1:0];
            size_q  <= sign_mask[2:0];
            sgn_q   <= sign_mask[3];
            wdata_q <= wr_data[15:0];
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: scoreboard bench for data_mem_ctrl with a behavioural SRAM and reference memory.
// Honours DMEM_MISALIGN_TRAP_EN when computing expected alignment behaviour.
module tb_data_mem_ctrl;
    logic        clk = 0;
    logic        rst_n = 0;
    logic [31:0] addr = 0, wr_data = 0;
    logic        memwrite = 0, memread = 0;
    logic [3:0]  sign_mask = 0;
    logic [31:0] rd_data;
    logic        rd_valid, busy, fault;
    logic [9:0]  sram_addr;
    logic [31:0] sram_wdata, sram_rdata = 0;
    logic        sram_we, sram_re;
    logic [31:0] mem [0:1023] = '{default: 32'h0};
    logic [31:0] ref_mem [0:1023] = '{default: 32'h0};
    logic [31:0] exp_q [$];
    int n_chk = 0, n_pass = 0, n_we = 0, n_wr = 0;
    data_mem_ctrl #(.ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wr_data(wr_data), .memwrite(memwrite),
        .memread(memread), .sign_mask(sign_mask), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .fault(fault), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_we(sram_we), .sram_re(sram_re), .sram_rdata(sram_rdata)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (sram_we) mem[sram_addr] <= sram_wdata;
        if (sram_re) sram_rdata <= mem[sram_addr];
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask
    always @(negedge clk) begin
        if (rst_n && sram_we) n_we++;
        if (rd_valid) begin
            if (exp_q.size() == 0) check("rd_spurious", 32'(rd_valid), 0);
            else check("rd_data", rd_data, exp_q.pop_front());
        end
    end
    function automatic logic misal(input logic [31:0] a, input logic [3:0] m);
`ifdef DMEM_MISALIGN_TRAP_EN
        return (m[2:0] == 3'b011 && a[0]) || (m[2:0] == 3'b111 && a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction
    function automatic logic [31:0] fmt(input logic [31:0] w, input logic [1:0] ln, input logic [3:0] m);
        logic [7:0]  b = w[{ln, 3'b000} +: 8];
        logic [15:0] h = ln[1] ? w[31:16] : w[15:0];
        if (m[2:0] == 3'b111) return w;
        if (m[2:0] == 3'b011) return m[3] ? 32'($signed(h)) : 32'(h);
        return m[3] ? 32'($signed(b)) : 32'(b);
    endfunction
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input logic also_rd);
        logic        word = m[2:0] == 3'b111;
        logic [31:0] w = ref_mem[a[11:2]];
        if (word) w = d;
        else if (m[2:0] == 3'b011) w[{a[1], 4'b0000} +: 16] = d[15:0];
        else w[{a[1:0], 3'b000} +: 8] = d[7:0];
        ref_mem[a[11:2]] = w;
        n_wr++;
        addr = a; wr_data = d; sign_mask = m; memwrite = 1; memread = also_rd;
        #1;
        check("st_busy0", 32'(busy), 0);
        check("st_we0", 32'(sram_we), 32'(word));
        check("st_re0", 32'(sram_re), 32'(!word));
        check("st_addr0", 32'(sram_addr), 32'(a[11:2]));
        if (word) check("st_wdata0", sram_wdata, d);
        @(posedge clk); #1;
        if (!word) begin
            check("st_busy1", 32'(busy), 1);
            check("st_we1", 32'(sram_we), 1);
            check("st_re1", 32'(sram_re), 0);
            check("st_addr1", 32'(sram_addr), 32'(a[11:2]));
            check("st_merge", sram_wdata, w);
            @(posedge clk); #1;
        end
        memwrite = 0; memread = 0;
        check("st_busy_end", 32'(busy), 0);
    endtask
    task automatic load(input logic [31:0] a, input logic [3:0] m);
        logic mis = misal(a, m);
        addr = a; sign_mask = m; memread = 1; memwrite = 0;
        #1;
        check("ld_busy0", 32'(busy), 0);
        check("ld_re0", 32'(sram_re), 32'(!mis));
        check("ld_we0", 32'(sram_we), 0);
        if (!mis) begin
            check("ld_addr0", 32'(sram_addr), 32'(a[11:2]));
            exp_q.push_back(fmt(ref_mem[a[11:2]], a[1:0], m));
        end
        @(posedge clk); #1;
        check("ld_busy1", 32'(busy), 32'(!mis));
        check("ld_fault1", 32'(fault), 32'(mis));
        check("ld_re1", 32'(sram_re), 0);
        if (mis) begin
            memread = 0;
            @(posedge clk); #1;
            check("ld_fault2", 32'(fault), 0);
            check("ld_novalid", 32'(rd_valid), 0);
        end else begin
            @(posedge clk); #1;
            memread = 0;
            check("ld_valid", 32'(rd_valid), 1);
        end
    endtask
    initial begin
        int bad;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_we", 32'(sram_we), 0);
        rst_n = 1;
        @(posedge clk); #1;
        check("rst_rd_data", rd_data, 0);
        check("rst_valid", 32'(rd_valid), 0);
        store(32'h10, 32'hDEADBEEF, 4'h7, 0);
        load(32'h10, 4'h7);
        // Abandon a load mid-flight with a three-cycle reset
        addr = 32'h10; sign_mask = 4'h7; memread = 1;
        @(posedge clk); #1;
        check("rl_busy", 32'(busy), 1);
        rst_n = 0; memread = 0;
        #1;
        check("rl_busy_rst", 32'(busy), 0);
        check("rl_we_rst", 32'(sram_we), 0);
        check("rl_re_rst", 32'(sram_re), 0);
        repeat (3) begin
            @(posedge clk); #1;
            check("rl_valid", 32'(rd_valid), 0);
            check("rl_rd_data", rd_data, 0);
        end
        rst_n = 1;
        @(posedge clk); #1;
        check("rl_after", rd_data, 0);
        store(32'h10, 32'h11223344, 4'h7, 0);
        store(32'h13, 32'h00000080, 4'h1, 0);
        load(32'h13, 4'h9);
        load(32'h13, 4'h1);
        load(32'h10, 4'h7);
        store(32'h22, 32'h0000BEEF, 4'h3, 0);
        load(32'h22, 4'hB);
        load(32'h20, 4'hB);
        store(32'h04, 32'h00000005, 4'h7, 1);
        store(32'h31, 32'h000000A5, 4'h1, 1);
        load(32'h04, 4'h7);
        load(32'h06, 4'h7);
        load(32'h31, 4'h9);
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a = $urandom_range(0, 63);
            logic [3:0]  m;
            int sz = $urandom_range(0, 2);
            m = {1'($urandom_range(0, 1)), sz == 0 ? 3'b001 : sz == 1 ? 3'b011 : 3'b111};
            if (sz == 1) a[0] = 0;
            if (sz == 2) a[1:0] = 0;
            if ($urandom_range(0, 1) == 1) store(a, $urandom, m, 0);
            else load(a, m);
        end
        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", exp_q.size(), 0);
        check("we_count", n_we, n_wr);
        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("mem_image", bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
